duty_ramp_limiter: RTL
======================

Name: duty_ramp_limiter

Overview:
- Upstream stage of the BLDC driver. Converts a signed speed command from the SPI/command register bank into the unsigned duty_cycle magnitude and direction bit the driver consumes.
- Enforces a slew-rate limit on duty changes.
- On a sign change, forces a ramp to zero and a dwell time before the direction flips, so the driver never sees a hard reversal at nonzero duty.

Parameters:
- DUTY_CYCLE_WIDTH, 10: width of duty_cycle output; command is DUTY_CYCLE_WIDTH+1 bits, two's complement.
- MAX_DUTY_CYCLE, 'h3FF: saturation limit for output magnitude.
- STEP_SIZE, 1: duty change per ramp tick.
- STEP_DIVIDER, 1024: clk cycles per ramp tick (>=1).
- REVERSE_HOLD_CYCLES, 4096: clk cycles duty is held at 0 before a direction flip (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  block enable; low forces output to zero
- cmd  in  DUTY_CYCLE_WIDTH+1  signed duty command, two's complement
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- fault_in  in  1  fault from BLDC driver
- duty_cycle  out  DUTY_CYCLE_WIDTH  ramped magnitude to driver
- direction  out  1  1 = forward (cmd >= 0), 0 = reverse
- at_target  out  1  output equals latched target
- busy_reverse  out  1  high in DECEL_REV or HOLD

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - duty_cycle=0, direction=1, target magnitude=0, target direction=1, at_target=1, busy_reverse=0, cmd_ready=0.
  - state=IDLE; prescaler and hold counter cleared.
- cmd_ready = en & rst_n, registered (high one cycle after reset release with en=1).
- Command capture (cmd_valid & cmd_ready):
  - Target magnitude = |cmd|, saturated to MAX_DUTY_CYCLE; the most-negative cmd saturates too.
  - Target direction = ~cmd[MSB]. A zero cmd keeps the previous target direction.
  - The new target takes effect on the next cycle; a later capture overwrites it at any time, including mid-ramp or mid-hold.
- Prescaler: free-runs 0..STEP_DIVIDER-1 while en=1; tick asserted for the one cycle it equals STEP_DIVIDER-1. Held at 0 when en=0.
- States:
  - IDLE: duty_cycle=0.
    - Target magnitude>0 and target dir==direction -> RAMP.
    - Target magnitude>0 and dir differs -> HOLD.
  - RAMP: on tick, duty moves toward target magnitude by STEP_SIZE, clamped to land exactly on target (no overshoot; compute with one extra bit, no wrap).
    - Target dir != direction -> DECEL_REV.
    - Duty==0 and target==0 -> IDLE.
  - DECEL_REV: on tick, duty decreases by STEP_SIZE, clamped at 0.
    - Duty==0 -> HOLD, with hold counter loaded to REVERSE_HOLD_CYCLES-1.
    - If target dir returns to direction before duty reaches 0 -> RAMP, with no flip and no hold.
  - HOLD: duty=0; counter decrements every clk.
    - At counter 0: direction <= target dir; go to RAMP if target magnitude>0, else IDLE.
    - If target dir changes back to direction during HOLD: go to IDLE immediately; direction is unchanged.
  - FAULT: duty_cycle=0; direction held.
    - Exit to IDLE only when fault_in=0 and target magnitude==0, i.e. host must send a zero command to rearm.
- Priority per cycle: rst_n > en=0 > fault_in > state logic.
  - en=0: state->IDLE, duty=0, counters cleared; direction and target retained. cmd_ready drops the next cycle.
  - fault_in=1 from any state: FAULT, duty=0 the next cycle; prescaler keeps running.
- at_target = (duty_cycle==target magnitude) & (direction==target dir), registered with outputs.
- busy_reverse = state in {DECEL_REV, HOLD}.
- Output latency: duty_cycle changes exactly one clk after the tick cycle; no combinational path from any input to any output.

Test Plan:
- Reset, en=1, STEP_DIVIDER=4, cmd=+8 -> duty steps 0,1,...,8 one per 4 clks, reaching 8 at 32+-1 clks after capture; direction=1; at_target=1 from then on.
- At duty=8, cmd=-5 -> duty ramps 8..0; busy_reverse=1; duty=0 for exactly REVERSE_HOLD_CYCLES clks; direction goes to 0; duty ramps to 5; busy_reverse clears on entering RAMP.
- During HOLD, cmd=+3 -> IDLE immediately, direction stays 1, then ramps to 3 with no further hold.
- cmd = most negative (-1024, width 11) -> target magnitude saturates to 1023; with STEP_SIZE=4, final step lands exactly on 1023 with no overshoot or wrap.
- At duty=8, pulse fault_in=1 for 1 clk -> duty=0 the next clk and FAULT persists; cmd=+8 is ignored; cmd=0 -> IDLE; cmd=+8 ramps from 0 again.
- Mid-ramp (duty=4), en=0 -> duty=0 and cmd_ready=0 the next clk. rst_n=0 mid-HOLD -> all outputs return to reset values the next clk.

Source files
------------

// File: rtl/duty_ramp_limiter.sv
`default_nettype none
// ============================================================================
// Module   : duty_ramp_limiter
// Purpose  : Signed speed command -> slew-limited duty magnitude + direction,
//            with a forced ramp to zero and dwell before any reversal.
// Revision : 1.0  initial release
// ============================================================================
module duty_ramp_limiter #(
    parameter int DUTY_CYCLE_WIDTH    = 10,
    parameter int MAX_DUTY_CYCLE      = 'h3FF,
    parameter int STEP_SIZE           = 1,
    parameter int STEP_DIVIDER        = 1024,
    parameter int REVERSE_HOLD_CYCLES = 4096
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [DUTY_CYCLE_WIDTH:0]   cmd,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        fault_in,
    output logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle,
    output logic                        direction,
    output logic                        at_target,
    output logic                        busy_reverse
);

    localparam int W  = DUTY_CYCLE_WIDTH;
    localparam int PW = (STEP_DIVIDER > 1) ? $clog2(STEP_DIVIDER) : 1;
    localparam int HW = (REVERSE_HOLD_CYCLES > 1) ? $clog2(REVERSE_HOLD_CYCLES) : 1;

    localparam logic [W-1:0]  c_max        = W'(MAX_DUTY_CYCLE);
    localparam logic [W-1:0]  c_step       = W'(STEP_SIZE);
    localparam logic [PW-1:0] c_presc_last = PW'(STEP_DIVIDER - 1);
    localparam logic [HW-1:0] c_hold_load  = HW'(REVERSE_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP      = 3'd1,
        ST_DECEL_REV = 3'd2,
        ST_HOLD      = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  duty_q, duty_d;
    logic          dir_q, dir_d;
    logic [W-1:0]  tgt_mag_q, tgt_mag_d;
    logic          tgt_dir_q, tgt_dir_d;
    logic          at_target_q, at_target_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [HW-1:0] hold_q, hold_d;

    logic          w_capture;
    logic [W:0]    w_cmd_abs;
    logic          w_tick;
    logic          w_same_dir;
    logic [W-1:0]  w_goal;
    logic [W:0]    w_up;
    logic [W:0]    w_dn_room;
    logic [W-1:0]  w_step;
    logic [W-1:0]  w_duty_stepped;

    assign w_capture  = cmd_valid & cmd_ready_q;
    // One extra bit so the most-negative command yields 2^W rather than wrapping.
    assign w_cmd_abs  = cmd[W] ? (~cmd + (W+1)'(1)) : cmd;
    assign w_tick     = en & (presc_q == c_presc_last);
    assign w_same_dir = (tgt_dir_q == dir_q);
    assign w_goal     = w_same_dir ? tgt_mag_q : '0;

    // Step toward the goal, landing exactly on it instead of overshooting.
    assign w_up      = {1'b0, duty_q} + {1'b0, c_step};
    assign w_dn_room = {1'b0, duty_q} - {1'b0, w_goal};

    always_comb begin
        w_step = duty_q;
        if (w_goal > duty_q) begin
            w_step = (w_up >= {1'b0, w_goal}) ? w_goal : w_up[W-1:0];
        end else if (w_goal < duty_q) begin
            w_step = (w_dn_room <= {1'b0, c_step}) ? w_goal : (duty_q - c_step);
        end
    end

    assign w_duty_stepped = w_tick ? w_step : duty_q;

    always_comb begin
        state_d     = state_q;
        duty_d      = duty_q;
        dir_d       = dir_q;
        presc_d     = presc_q;
        hold_d      = hold_q;
        cmd_ready_d = en;
        tgt_mag_d   = tgt_mag_q;
        tgt_dir_d   = tgt_dir_q;

        if (w_capture) begin
            tgt_mag_d = (w_cmd_abs > {1'b0, c_max}) ? c_max : w_cmd_abs[W-1:0];
            if (cmd != '0) begin
                tgt_dir_d = ~cmd[W];
            end
        end

        if (!en) begin
            state_d = ST_IDLE;
            duty_d  = '0;
            presc_d = '0;
            hold_d  = '0;
        end else begin
            presc_d = (presc_q == c_presc_last) ? '0 : presc_q + PW'(1);
            if (fault_in) begin
                state_d = ST_FAULT;
                duty_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        duty_d = '0;
                        if (tgt_mag_q != '0) begin
                            if (w_same_dir) begin
                                state_d = ST_RAMP;
                            end else begin
                                state_d = ST_HOLD;
                                hold_d  = c_hold_load;
                            end
                        end
                    end
                    ST_RAMP: begin
                        duty_d = w_duty_stepped;
                        if (!w_same_dir) begin
                            state_d = ST_DECEL_REV;
                        end else if (duty_q == '0 && tgt_mag_q == '0) begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_DECEL_REV: begin
                        if (duty_q == '0) begin
                            state_d = ST_HOLD;
                            hold_d  = c_hold_load;
                        end else begin
                            duty_d = w_duty_stepped;
                            if (w_same_dir) begin
                                state_d = ST_RAMP;
                            end
                        end
                    end
                    ST_HOLD: begin
                        duty_d = '0;
                        if (w_same_dir) begin
                            state_d = ST_IDLE;
                            hold_d  = '0;
                        end else if (hold_q == '0) begin
                            dir_d   = tgt_dir_q;
                            state_d = (tgt_mag_q != '0) ? ST_RAMP : ST_IDLE;
                        end else begin
                            hold_d = hold_q - HW'(1);
                        end
                    end
                    ST_FAULT: begin
                        // Rearm only after the host has parked the target at zero.
                        duty_d = '0;
                        if (tgt_mag_q == '0) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        duty_d  = '0;
                    end
                endcase
            end
        end

        at_target_d = (duty_d == tgt_mag_d) && (dir_d == tgt_dir_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            duty_q      <= '0;
            dir_q       <= 1'b1;
            tgt_mag_q   <= '0;
            tgt_dir_q   <= 1'b1;
            at_target_q <= 1'b1;
            cmd_ready_q <= 1'b0;
            presc_q     <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            dir_q       <= dir_d;
            tgt_mag_q   <= tgt_mag_d;
            tgt_dir_q   <= tgt_dir_d;
            at_target_q <= at_target_d;
            cmd_ready_q <= cmd_ready_d;
            presc_q     <= presc_d;
            hold_q      <= hold_d;
        end
    end

    assign duty_cycle   = duty_q;
    assign direction    = dir_q;
    assign at_target    = at_target_q;
    assign cmd_ready    = cmd_ready_q;
    assign busy_reverse = (state_q == ST_DECEL_REV) || (state_q == ST_HOLD);

endmodule
`default_nettype wire
